// File: rtl/gbus_packet_arbiter.sv
// Round-robin drain of N bus packet FIFOs onto one valid/ready channel.
// Read data lands one cycle after rd_en into a 2-entry output/skid buffer.
module gbus_packet_arbiter #(
   parameter int N_SRC = 4,
   parameter int PKT_W = 32,
   parameter int SRC_W = $clog2(N_SRC)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_SRC-1:0]            fifo_empty,
   input  logic [N_SRC-1:0][PKT_W-1:0] fifo_data,
   input  logic [N_SRC-1:0]            fifo_full_err,
   output logic [N_SRC-1:0]            fifo_rd_en,
   output logic                        bus_valid,
   output logic [PKT_W-1:0]            bus_packet,
   output logic [SRC_W-1:0]            bus_src,
   input  logic                        bus_ready,
   output logic [N_SRC-1:0]            err_sticky
);

   logic [SRC_W-1:0] r_rr_ptr;
   logic             r_pend_v;
   logic [SRC_W-1:0] r_pend_src;
   logic             r_out_v;
   logic [PKT_W-1:0] r_out_pkt;
   logic [SRC_W-1:0] r_out_src;
   logic             r_skd_v;
   logic [PKT_W-1:0] r_skd_pkt;
   logic [SRC_W-1:0] r_skd_src;
   logic [N_SRC-1:0] r_err;

   logic             w_pop;
   logic [1:0]       w_cnt;
   logic             w_credit;
   logic             w_found;
   logic [SRC_W-1:0] w_gnt;
   logic [SRC_W-1:0] w_scan;
   int               w_j;
   logic             w_issue;
   logic [PKT_W-1:0] w_land_pkt;
   logic             w_to_out;

   assign w_pop = r_out_v & bus_ready;
   assign w_cnt = {1'b0, r_out_v} + {1'b0, r_skd_v} + {1'b0, r_pend_v};
   // A read must always find a free slot when it lands next cycle.
   assign w_credit = w_cnt < (2'd2 + {1'b0, w_pop});

   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_scan  = '0;
      w_j     = 0;
      for (int k = 1; k <= N_SRC; k++) begin
         w_j    = (int'(r_rr_ptr) + k) % N_SRC;
         w_scan = SRC_W'(w_j);
         if (!w_found && !fifo_empty[w_scan]) begin
            w_found = 1'b1;
            w_gnt   = w_scan;
         end
      end
   end

   assign w_issue = w_credit & w_found;

   always_comb begin
      fifo_rd_en = '0;
      if (w_issue) begin
         fifo_rd_en[w_gnt] = 1'b1;
      end
   end

   assign w_land_pkt = fifo_data[r_pend_src];
   assign w_to_out   = r_pend_v & (~r_out_v | w_pop) & ~r_skd_v;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr   <= SRC_W'(N_SRC - 1);
         r_pend_v   <= 1'b0;
         r_pend_src <= '0;
      end else begin
         r_pend_v <= w_issue;
         if (w_issue) begin
            r_pend_src <= w_gnt;
            r_rr_ptr   <= w_gnt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_v   <= 1'b0;
         r_out_pkt <= '0;
         r_out_src <= '0;
      end else if (w_pop && r_skd_v) begin
         r_out_v   <= 1'b1;
         r_out_pkt <= r_skd_pkt;
         r_out_src <= r_skd_src;
      end else if (w_to_out) begin
         r_out_v   <= 1'b1;
         r_out_pkt <= w_land_pkt;
         r_out_src <= r_pend_src;
      end else if (w_pop) begin
         r_out_v <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_skd_v   <= 1'b0;
         r_skd_pkt <= '0;
         r_skd_src <= '0;
      end else if (r_pend_v && !w_to_out) begin
         r_skd_v   <= 1'b1;
         r_skd_pkt <= w_land_pkt;
         r_skd_src <= r_pend_src;
      end else if (w_pop && r_skd_v) begin
         r_skd_v <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= '0;
      end else begin
         r_err <= r_err | fifo_full_err;
      end
   end

   assign bus_valid  = r_out_v;
   assign bus_packet = r_out_pkt;
   assign bus_src    = r_out_src;
   assign err_sticky = r_err;

endmodule

// File: tb/tb_gbus_packet_arbiter.sv
// Self-checking bench for gbus_packet_arbiter with behavioural FIFOs
// and a per-source scoreboard of expected packets.
module tb_gbus_packet_arbiter;

   localparam int N = 4;
   localparam int W = 32;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [N-1:0]        fifo_empty;
   logic [N-1:0][W-1:0] fifo_data;
   logic [N-1:0]        fifo_full_err;
   logic [N-1:0]        fifo_rd_en;
   logic                bus_valid;
   logic [W-1:0]        bus_packet;
   logic [1:0]          bus_src;
   logic                bus_ready;
   logic [N-1:0]        err_sticky;

   logic [W-1:0] q[N][$];
   logic [W-1:0] exp_q[N][$];
   logic [N-1:0] rd_s;
   int           n_tests = 0;
   int           n_fail  = 0;
   int           seq_n   = 0;

   gbus_packet_arbiter #(.N_SRC(N), .PKT_W(W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fifo_empty    (fifo_empty),
      .fifo_data     (fifo_data),
      .fifo_full_err (fifo_full_err),
      .fifo_rd_en    (fifo_rd_en),
      .bus_valid     (bus_valid),
      .bus_packet    (bus_packet),
      .bus_src       (bus_src),
      .bus_ready     (bus_ready),
      .err_sticky    (err_sticky)
   );

   always #5 clk = ~clk;

   task automatic push(input int s);
      logic [W-1:0] p;
      p = {8'(s), 8'($urandom_range(0, 255)), 16'(seq_n)};
      seq_n++;
      q[s].push_back(p);
      exp_q[s].push_back(p);
      fifo_empty[s] = 1'b0;
   endtask

   task automatic settle(input logic rdy);
      bus_ready = rdy;
      #1;
   endtask

   // FIFO model: a read strobe pops at the edge, data valid next cycle.
   task automatic advance();
      rd_s = fifo_rd_en;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (rd_s[i] && q[i].size() > 0) fifo_data[i] = q[i].pop_front();
         fifo_empty[i] = (q[i].size() == 0);
      end
      @(negedge clk);
   endtask

   task automatic clear_fifos();
      for (int i = 0; i < N; i++) begin
         q[i].delete();
         exp_q[i].delete();
      end
      fifo_empty = '1;
      fifo_data  = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus_ready = 1'b0;
      fifo_full_err = '0;
      clear_fifos();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      n_tests++;
      if (fifo_rd_en !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_rd_en got %b want 0000", fifo_rd_en);
      end
      n_tests++;
      if (bus_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid got %b want 0", bus_valid);
      end
      n_tests++;
      if (bus_packet !== 32'h0 || bus_src !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_pkt got %h/%0d want 0/0", bus_packet, bus_src);
      end
      n_tests++;
      if (err_sticky !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_err got %b want 0000", err_sticky);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      logic [W-1:0] e;
      push(2);
      settle(1'b1);
      n_tests++;
      if (fifo_rd_en !== 4'b0100) begin
         n_fail++;
         $display("FAIL single_rd got %b want 0100", fifo_rd_en);
      end
      advance();
      settle(1'b1);
      n_tests++;
      if (bus_valid !== 1'b0 || fifo_rd_en !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_t1 got v=%b rd=%b want v=0 rd=0000", bus_valid, fifo_rd_en);
      end
      advance();
      settle(1'b1);
      e = exp_q[2].pop_front();
      n_tests++;
      if (bus_valid !== 1'b1 || bus_src !== 2'd2 || bus_packet !== e) begin
         n_fail++;
         $display("FAIL single_t2 got v=%b src=%0d pkt=%h want v=1 src=2 pkt=%h", bus_valid, bus_src, bus_packet, e);
      end
      advance();
      for (int c = 0; c < 4; c++) begin
         settle(1'b1);
         n_tests++;
         if (fifo_rd_en !== 4'b0000 || bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle got rd=%b v=%b want 0000/0", fifo_rd_en, bus_valid);
         end
         advance();
      end
   endtask

   task automatic test_round_robin();
      logic [W-1:0] e;
      int first, last, pops;
      do_reset();
      for (int r = 0; r < 3; r++)
         for (int s = 0; s < N; s++) push(s);
      first = -1;
      last = -1;
      pops = 0;
      for (int c = 0; c < 30; c++) begin
         settle(1'b1);
         if (fifo_empty != 4'b1111) begin
            n_tests++;
            if (fifo_rd_en == 4'b0000) begin
               n_fail++;
               $display("FAIL rr_rate cycle %0d got rd=0000 want a strobe", c);
            end
         end
         if (bus_valid) begin
            if (first < 0) first = c;
            last = c;
            n_tests++;
            if (bus_src !== 2'(pops % N)) begin
               n_fail++;
               $display("FAIL rr_order pop %0d got src=%0d want %0d", pops, bus_src, pops % N);
            end
            e = exp_q[bus_src].size() > 0 ? exp_q[bus_src].pop_front() : 32'hx;
            n_tests++;
            if (bus_packet !== e) begin
               n_fail++;
               $display("FAIL rr_data got %h want %h", bus_packet, e);
            end
            pops++;
         end
         advance();
      end
      n_tests++;
      if (pops != 12 || last - first != 11) begin
         n_fail++;
         $display("FAIL rr_count got pops=%0d span=%0d want 12/11", pops, last - first);
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] e, first_pkt;
      int rd_cnt, pops;
      do_reset();
      for (int i = 0; i < 5; i++) push(0);
      first_pkt = exp_q[0][0];
      rd_cnt = 0;
      pops = 0;
      for (int c = 0; c < 10; c++) begin
         settle(1'b0);
         if (fifo_rd_en != 4'b0000) rd_cnt++;
         if (bus_valid) begin
            n_tests++;
            if (bus_packet !== first_pkt) begin
               n_fail++;
               $display("FAIL bp_hold got %h want %h", bus_packet, first_pkt);
            end
         end
         advance();
      end
      n_tests++;
      if (rd_cnt != 2 || bus_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_fill got rd=%0d v=%b want 2/1", rd_cnt, bus_valid);
      end
      for (int c = 0; c < 20; c++) begin
         settle(1'b1);
         if (fifo_rd_en != 4'b0000) rd_cnt++;
         if (pops > 0 && pops < 5) begin
            n_tests++;
            if (bus_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL bp_gap after pop %0d got v=0 want 1", pops);
            end
         end
         if (bus_valid) begin
            e = exp_q[0].size() > 0 ? exp_q[0].pop_front() : 32'hx;
            n_tests++;
            if (bus_packet !== e || bus_src !== 2'd0) begin
               n_fail++;
               $display("FAIL bp_data got %h/%0d want %h/0", bus_packet, bus_src, e);
            end
            pops++;
         end
         advance();
      end
      n_tests++;
      if (pops != 5 || rd_cnt != 5) begin
         n_fail++;
         $display("FAIL bp_total got pops=%0d rd=%0d want 5/5", pops, rd_cnt);
      end
   endtask

   task automatic test_random_stall();
      logic [W-1:0] e;
      int held, left;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         if (c < 450 && $urandom_range(0, 2) == 0) push($urandom_range(0, N - 1));
         settle(1'($urandom_range(0, 1)));
         n_tests++;
         if ((fifo_rd_en & fifo_empty) != 4'b0000 || $countones(fifo_rd_en) > 1) begin
            n_fail++;
            $display("FAIL rnd_rd got rd=%b empty=%b want one-hot to non-empty", fifo_rd_en, fifo_empty);
         end
         held = int'(dut.r_out_v) + int'(dut.r_skd_v) + int'(dut.r_pend_v);
         n_tests++;
         if (held > 2) begin
            n_fail++;
            $display("FAIL rnd_credit got held+pend=%0d want <=2", held);
         end
         if (bus_valid && bus_ready) begin
            n_tests++;
            if (exp_q[bus_src].size() == 0) begin
               n_fail++;
               $display("FAIL rnd_dup got %h from src %0d want nothing", bus_packet, bus_src);
            end else begin
               e = exp_q[bus_src].pop_front();
               if (bus_packet !== e) begin
                  n_fail++;
                  $display("FAIL rnd_data src %0d got %h want %h", bus_src, bus_packet, e);
               end
            end
         end
         advance();
      end
      for (int c = 0; c < 300; c++) begin
         settle(1'b1);
         if (bus_valid) begin
            n_tests++;
            e = exp_q[bus_src].size() > 0 ? exp_q[bus_src].pop_front() : 32'hx;
            if (bus_packet !== e) begin
               n_fail++;
               $display("FAIL drain_data src %0d got %h want %h", bus_src, bus_packet, e);
            end
         end
         advance();
      end
      left = 0;
      for (int i = 0; i < N; i++) left += exp_q[i].size();
      n_tests++;
      if (left != 0 || bus_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rnd_loss got %0d undelivered v=%b want 0/0", left, bus_valid);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 5; i++) push(1);
      settle(1'b0);
      advance();
      settle(1'b0);
      advance();
      settle(1'b0);
      n_tests++;
      if (dut.r_out_v !== 1'b1 || dut.r_pend_v !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_setup got out_v=%b pend_v=%b want 1/1", dut.r_out_v, dut.r_pend_v);
      end
      rst_n = 1'b0;
      clear_fifos();
      #1;
      n_tests++;
      if (bus_valid !== 1'b0 || fifo_rd_en !== 4'b0000) begin
         n_fail++;
         $display("FAIL mid_reset got v=%b rd=%b want 0/0000", bus_valid, fifo_rd_en);
      end
      @(negedge clk);
      rst_n = 1'b1;
      push(2);
      push(3);
      push(1);
      push(0);
      settle(1'b1);
      n_tests++;
      if (fifo_rd_en !== 4'b0001) begin
         n_fail++;
         $display("FAIL mid_first got rd=%b want 0001", fifo_rd_en);
      end
      advance();
   endtask

   task automatic test_error();
      do_reset();
      fifo_full_err = 4'b1000;
      settle(1'b0);
      n_tests++;
      if (err_sticky !== 4'b0000) begin
         n_fail++;
         $display("FAIL err_early got %b want 0000", err_sticky);
      end
      advance();
      fifo_full_err = 4'b0000;
      for (int c = 0; c < 5; c++) begin
         settle(1'b0);
         n_tests++;
         if (err_sticky !== 4'b1000) begin
            n_fail++;
            $display("FAIL err_sticky cycle %0d got %b want 1000", c, err_sticky);
         end
         advance();
      end
      do_reset();
      settle(1'b0);
      n_tests++;
      if (err_sticky !== 4'b0000) begin
         n_fail++;
         $display("FAIL err_clear got %b want 0000", err_sticky);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus_ready = 1'b0;
      fifo_full_err = '0;
      fifo_empty = '1;
      fifo_data = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_random_stall();
      test_reset_mid();
      test_error();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
